// File: rtl/fwvexrisc_rvfi_seq.sv
// ---------------------------------------------------------------------------
// fwvexrisc_rvfi_seq
//
// Captures RVFI retirement records from a core into a small show-ahead FIFO
// and presents them to a debug BFM with a valid/ready handshake. It also
// checks that rvfi_order increments by one per retirement, and stops
// capturing once a halt retirement has been seen.
//
// Ports
//   clock, reset          single clock, synchronous active-high reset
//   en                    capture enable (0 = retirements discarded)
//   rvfi_*                retirement record from the core
//   dbg_valid/dbg_ready   head-record handshake towards the debug BFM
//   dbg_*                 head-record fields (0 while the FIFO is empty)
//   halted                halt record delivered and FIFO drained
//   order_err             sticky: rvfi_order discontinuity seen
//   ovf                   sticky: a record was dropped on a full FIFO
//   drop_cnt              number of dropped records, saturating
// ---------------------------------------------------------------------------
module fwvexrisc_rvfi_seq #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic        rvfi_valid,
    input  logic [63:0] rvfi_order,
    input  logic [31:0] rvfi_insn,
    input  logic        rvfi_trap,
    input  logic        rvfi_halt,
    input  logic        rvfi_intr,
    input  logic [4:0]  rvfi_rd_addr,
    input  logic [31:0] rvfi_rd_wdata,
    input  logic [31:0] rvfi_pc_rdata,
    input  logic [31:0] rvfi_mem_addr,
    input  logic [3:0]  rvfi_mem_wmask,
    input  logic [31:0] rvfi_mem_wdata,
    output logic        dbg_valid,
    input  logic        dbg_ready,
    output logic [31:0] dbg_insn,
    output logic        dbg_trap,
    output logic        dbg_intr,
    output logic [4:0]  dbg_rd_addr,
    output logic [31:0] dbg_rd_wdata,
    output logic [31:0] dbg_pc,
    output logic [31:0] dbg_mem_addr,
    output logic [3:0]  dbg_mem_wmask,
    output logic [31:0] dbg_mem_wdata,
    output logic        halted,
    output logic        order_err,
    output logic        ovf,
    output logic [15:0] drop_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [31:0] insn;
        logic        trap;
        logic        intr;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] pc;
        logic [31:0] mem_addr;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_wdata;
    } rec_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALTING,
        ST_HALTED
    } state_t;

    rec_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    state_t        state_q;
    logic          halted_q;
    logic [63:0]   exp_order_q;
    logic          order_err_q;
    logic          ovf_q;
    logic [15:0]   drop_cnt_q;

    logic capture;
    logic pop;
    logic push;
    logic drop;
    rec_t wr_rec;
    rec_t head_rec;

    // Only RUN accepts retirements; once a halt has been captured everything
    // after it is ignored without touching order check or drop accounting.
    assign capture = rvfi_valid && en && (state_q == ST_RUN);
    assign pop     = (count_q != '0) && dbg_ready;
    // A full FIFO still accepts a record when the head leaves the same cycle.
    assign push    = capture && ((count_q != DEPTH_C) || pop);
    assign drop    = capture && !push;
    assign count_d = count_q + CW'(push) - CW'(pop);

    always_comb begin
        wr_rec.insn      = rvfi_insn;
        wr_rec.trap      = rvfi_trap;
        wr_rec.intr      = rvfi_intr;
        wr_rec.rd_addr   = rvfi_rd_addr;
        wr_rec.rd_wdata  = rvfi_rd_wdata;
        wr_rec.pc        = rvfi_pc_rdata;
        wr_rec.mem_addr  = rvfi_mem_addr;
        wr_rec.mem_wmask = rvfi_mem_wmask;
        wr_rec.mem_wdata = rvfi_mem_wdata;
    end

    // Storage has no reset: an empty FIFO masks whatever the entries hold.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_rec;
        end
    end

    // Control, checking and halt state machine.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= ST_RUN;
            halted_q    <= 1'b0;
            exp_order_q <= '0;
            order_err_q <= 1'b0;
            ovf_q       <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;

            // Expected order resynchronises to the observed one, so a single
            // gap raises order_err once rather than on every later record.
            if (capture) begin
                if (rvfi_order != exp_order_q) begin
                    order_err_q <= 1'b1;
                end
                exp_order_q <= rvfi_order + 64'd1;
            end

            if (drop) begin
                ovf_q <= 1'b1;
                if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_q <= drop_cnt_q + 16'd1;
                end
            end

            case (state_q)
                ST_RUN: begin
                    if (capture && rvfi_halt) begin
                        state_q <= ST_HALTING;
                    end
                end
                ST_HALTING: begin
                    // Looks at the post-pop count so halted rises the cycle
                    // right after the final record leaves.
                    if (count_d == '0) begin
                        state_q  <= ST_HALTED;
                        halted_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_HALTED;
                end
            endcase
        end
    end

    assign head_rec  = mem_q[rd_ptr_q];
    assign dbg_valid = (count_q != '0);

    always_comb begin
        dbg_insn      = '0;
        dbg_trap      = 1'b0;
        dbg_intr      = 1'b0;
        dbg_rd_addr   = '0;
        dbg_rd_wdata  = '0;
        dbg_pc        = '0;
        dbg_mem_addr  = '0;
        dbg_mem_wmask = '0;
        dbg_mem_wdata = '0;
        if (dbg_valid) begin
            dbg_insn      = head_rec.insn;
            dbg_trap      = head_rec.trap;
            dbg_intr      = head_rec.intr;
            dbg_rd_addr   = head_rec.rd_addr;
            dbg_rd_wdata  = head_rec.rd_wdata;
            dbg_pc        = head_rec.pc;
            dbg_mem_addr  = head_rec.mem_addr;
            dbg_mem_wmask = head_rec.mem_wmask;
            dbg_mem_wdata = head_rec.mem_wdata;
        end
    end

    assign halted    = halted_q;
    assign order_err = order_err_q;
    assign ovf       = ovf_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_fwvexrisc_rvfi_seq.sv
// ---------------------------------------------------------------------------
// tb_fwvexrisc_rvfi_seq
//
// Drives directed scenarios followed by randomized retirement traffic into
// fwvexrisc_rvfi_seq and compares every output, every cycle, against a
// queue-based reference model of the record stream.
// ---------------------------------------------------------------------------
module tb_fwvexrisc_rvfi_seq;

    localparam int DEPTH = 4;

    logic        clock;
    logic        reset;
    logic        en;
    logic        rvfi_valid;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn;
    logic        rvfi_trap;
    logic        rvfi_halt;
    logic        rvfi_intr;
    logic [4:0]  rvfi_rd_addr;
    logic [31:0] rvfi_rd_wdata;
    logic [31:0] rvfi_pc_rdata;
    logic [31:0] rvfi_mem_addr;
    logic [3:0]  rvfi_mem_wmask;
    logic [31:0] rvfi_mem_wdata;
    logic        dbg_valid;
    logic        dbg_ready;
    logic [31:0] dbg_insn;
    logic        dbg_trap;
    logic        dbg_intr;
    logic [4:0]  dbg_rd_addr;
    logic [31:0] dbg_rd_wdata;
    logic [31:0] dbg_pc;
    logic [31:0] dbg_mem_addr;
    logic [3:0]  dbg_mem_wmask;
    logic [31:0] dbg_mem_wdata;
    logic        halted;
    logic        order_err;
    logic        ovf;
    logic [15:0] drop_cnt;

    fwvexrisc_rvfi_seq #(.DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .en             (en),
        .rvfi_valid     (rvfi_valid),
        .rvfi_order     (rvfi_order),
        .rvfi_insn      (rvfi_insn),
        .rvfi_trap      (rvfi_trap),
        .rvfi_halt      (rvfi_halt),
        .rvfi_intr      (rvfi_intr),
        .rvfi_rd_addr   (rvfi_rd_addr),
        .rvfi_rd_wdata  (rvfi_rd_wdata),
        .rvfi_pc_rdata  (rvfi_pc_rdata),
        .rvfi_mem_addr  (rvfi_mem_addr),
        .rvfi_mem_wmask (rvfi_mem_wmask),
        .rvfi_mem_wdata (rvfi_mem_wdata),
        .dbg_valid      (dbg_valid),
        .dbg_ready      (dbg_ready),
        .dbg_insn       (dbg_insn),
        .dbg_trap       (dbg_trap),
        .dbg_intr       (dbg_intr),
        .dbg_rd_addr    (dbg_rd_addr),
        .dbg_rd_wdata   (dbg_rd_wdata),
        .dbg_pc         (dbg_pc),
        .dbg_mem_addr   (dbg_mem_addr),
        .dbg_mem_wmask  (dbg_mem_wmask),
        .dbg_mem_wdata  (dbg_mem_wdata),
        .halted         (halted),
        .order_err      (order_err),
        .ovf            (ovf),
        .drop_cnt       (drop_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] insn;
        logic        trap;
        logic        intr;
        logic [4:0]  rd;
        logic [31:0] rdw;
        logic [31:0] pc;
        logic [31:0] maddr;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } rec_t;

    rec_t        m_q[$];
    int          m_mode;      // 0 = accepting, 1 = halt seen, 2 = halted
    logic [63:0] m_exp;
    logic        m_err;
    logic        m_ovf;
    int          m_drop;
    bit          m_live;
    rec_t        blank;

    int n_cmp;
    int n_bad;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        rec_t e;
        e = (m_q.size() != 0) ? m_q[0] : blank;
        check_val("dbg_valid", dbg_valid, (m_q.size() != 0));
        check_val("dbg_insn", dbg_insn, e.insn);
        check_val("dbg_trap", dbg_trap, e.trap);
        check_val("dbg_intr", dbg_intr, e.intr);
        check_val("dbg_rd_addr", dbg_rd_addr, e.rd);
        check_val("dbg_rd_wdata", dbg_rd_wdata, e.rdw);
        check_val("dbg_pc", dbg_pc, e.pc);
        check_val("dbg_mem_addr", dbg_mem_addr, e.maddr);
        check_val("dbg_mem_wmask", dbg_mem_wmask, e.wmask);
        check_val("dbg_mem_wdata", dbg_mem_wdata, e.wdata);
        check_val("halted", halted, (m_mode == 2));
        check_val("order_err", order_err, m_err);
        check_val("ovf", ovf, m_ovf);
        check_val("drop_cnt", drop_cnt, 64'(m_drop));
    endtask

    // Advances the model by one clock edge using the inputs the DUT sampled.
    task automatic model_step();
        bit   popd;
        bit   cap;
        rec_t r;
        if (reset) begin
            m_q.delete();
            m_mode = 0;
            m_exp  = '0;
            m_err  = 1'b0;
            m_ovf  = 1'b0;
            m_drop = 0;
            m_live = 1'b1;
            return;
        end
        if (!m_live) return;
        popd = (m_q.size() != 0) && dbg_ready;
        cap  = rvfi_valid && en && (m_mode == 0);
        if (popd) begin
            $display("deliver pc=%08h insn=%08h rd=%0d queued_after=%0d",
                     m_q[0].pc, m_q[0].insn, m_q[0].rd, m_q.size() - 1);
            void'(m_q.pop_front());
        end
        if (cap) begin
            r.insn  = rvfi_insn;      r.trap  = rvfi_trap;
            r.intr  = rvfi_intr;      r.rd    = rvfi_rd_addr;
            r.rdw   = rvfi_rd_wdata;  r.pc    = rvfi_pc_rdata;
            r.maddr = rvfi_mem_addr;  r.wmask = rvfi_mem_wmask;
            r.wdata = rvfi_mem_wdata;
            if (m_q.size() < DEPTH) m_q.push_back(r);
            else begin
                m_ovf = 1'b1;
                if (m_drop < 65535) m_drop++;
            end
            if (rvfi_order != m_exp) m_err = 1'b1;
            m_exp = rvfi_order + 64'd1;
        end
        if (m_mode == 1 && m_q.size() == 0) m_mode = 2;
        else if (cap && rvfi_halt) m_mode = 1;
    endtask

    // One clock cycle: check outputs, drive inputs, take the edge, update model.
    task automatic step(input bit v, input logic [63:0] ord, input bit h,
                        input bit rdy, input bit e, input bit rst);
        @(negedge clock);
        if (m_live) compare_all();
        rvfi_valid     = v;
        rvfi_order     = ord;
        rvfi_halt      = h;
        dbg_ready      = rdy;
        en             = e;
        reset          = rst;
        rvfi_insn      = $urandom;
        rvfi_trap      = 1'($urandom_range(0, 1));
        rvfi_intr      = 1'($urandom_range(0, 1));
        rvfi_rd_addr   = 5'($urandom);
        rvfi_rd_wdata  = $urandom;
        rvfi_pc_rdata  = $urandom;
        rvfi_mem_addr  = $urandom;
        rvfi_mem_wmask = 4'($urandom);
        rvfi_mem_wdata = $urandom;
        @(posedge clock);
        model_step();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 64'd0, 1'b0, rdy, 1'b1, 1'b0);
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        m_live = 1'b0;
        m_mode = 0;
        m_exp  = '0;
        m_err  = 1'b0;
        m_ovf  = 1'b0;
        m_drop = 0;
        blank  = '{default: '0};
        reset = 1'b1; en = 1'b0; rvfi_valid = 1'b0; rvfi_order = '0;
        rvfi_halt = 1'b0; dbg_ready = 1'b0;
        rvfi_insn = '0; rvfi_trap = 1'b0; rvfi_intr = 1'b0; rvfi_rd_addr = '0;
        rvfi_rd_wdata = '0; rvfi_pc_rdata = '0; rvfi_mem_addr = '0;
        rvfi_mem_wmask = '0; rvfi_mem_wdata = '0;

        // Reset state
        step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        check_val("rst_dbg_valid", dbg_valid, 0);
        check_val("rst_drop_cnt", drop_cnt, 0);
        check_val("rst_halted", halted, 0);

        // In-order stream, consumer always ready
        for (int i = 0; i < 6; i++) step(1'b1, 64'(i), 1'b0, 1'b1, 1'b1, 1'b0);
        #2;
        check_val("stream_valid_after_last", dbg_valid, 1);
        idle(3, 1'b1);
        #2;
        check_val("stream_order_err", order_err, 0);
        check_val("stream_ovf", ovf, 0);

        // Overflow: six captures into a four-deep FIFO, then drain
        step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 64'(i), 1'b0, 1'b0, 1'b1, 1'b0);
        #2;
        check_val("ovf_drop_cnt", drop_cnt, 2);
        check_val("ovf_flag", ovf, 1);
        idle(5, 1'b1);
        #2;
        check_val("ovf_drained", dbg_valid, 0);

        // Full FIFO with simultaneous capture and pop
        step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 64'(i), 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 64'd4, 1'b0, 1'b1, 1'b1, 1'b0);
        #2;
        check_val("full_pop_drop_cnt", drop_cnt, 0);
        idle(6, 1'b1);

        // Order gap then resync; en=0 traffic ignored while queue drains
        step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 64'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 64'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        #2;
        check_val("gap_order_err", order_err, 1);
        step(1'b1, 64'd4, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 64'd9, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(5, 1'b1);

        // Halt with one record ahead of it; later retirements ignored
        step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 64'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 64'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 64'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        #2;
        check_val("halt_after_last_pop", halted, 1);
        step(1'b1, 64'd4, 1'b0, 1'b1, 1'b1, 1'b0);
        #2;
        check_val("halt_ignores_valid", dbg_valid, 0);

        // Reset with records queued and a coincident retirement
        step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 64'(i + 5), 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 64'd7, 1'b0, 1'b0, 1'b1, 1'b1);
        #2;
        check_val("rst_mid_valid", dbg_valid, 0);
        check_val("rst_mid_order_err", order_err, 0);
        step(1'b1, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(2, 1'b1);
        #2;
        check_val("rst_mid_resume_err", order_err, 0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic [63:0] ord;
            bit          rst;
            ord = ($urandom_range(0, 9) == 0) ? m_exp + 64'($urandom_range(2, 5)) : m_exp;
            rst = ($urandom_range(0, 99) == 0);
            step(($urandom_range(0, 9) < 6), ord, ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) != 0), rst);
        end
        idle(1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
